// File: rtl/capture_ctrl_if.sv
// capture_ctrl_if: sample RAM bus (sync write port, async read port, strobes)
interface capture_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              ram_cs;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr_in;
  logic [DATA_W-1:0] ram_data_in;
  logic              ram_oe;
  logic [ADDR_W-1:0] ram_addr_out;
  logic [DATA_W-1:0] ram_data_out;
  modport master (
    output ram_cs, ram_we, ram_addr_in, ram_data_in, ram_oe, ram_addr_out,
    input  ram_data_out
  );
  modport slave (
    input  ram_cs, ram_we, ram_addr_in, ram_data_in, ram_oe, ram_addr_out,
    output ram_data_out
  );
endinterface

// File: rtl/capture_ctrl.sv
// capture_ctrl: circular-buffer capture sequencer with level/edge trigger and trigger-relative readout
module capture_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic              force_trig_i,
  input  logic              sample_valid_i,
  input  logic [DATA_W-1:0] sample_in_i,
  input  logic [DATA_W-1:0] trig_level_i,
  input  logic              trig_falling_i,
  input  logic [ADDR_W-1:0] pretrig_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_idx_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              busy_o,
  output logic              triggered_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] start_addr_o,
  capture_ctrl_if.master    bus
);
  typedef enum logic [2:0] {IDLE, PRE, WAIT_TRIG, POST, DONE} state_t;
  state_t            state_q;
  logic [ADDR_W-1:0] wr_ptr_q, cnt_q, p_q, start_addr_q, waddr_q;
  logic [DATA_W-1:0] prev_q, wdata_q;
  logic              prev_ok_q, busy_q, done_q, triggered_q, we_q;
  logic              accept, edge_hit, trig;
  logic [ADDR_W-1:0] cnt_nxt;
  assign accept   = sample_valid_i && (state_q inside {PRE, WAIT_TRIG, POST});
  assign edge_hit = trig_falling_i ? (prev_q > trig_level_i && sample_in_i <= trig_level_i)
                                   : (prev_q < trig_level_i && sample_in_i >= trig_level_i);
  assign trig     = force_trig_i || (prev_ok_q && edge_hit);
  assign cnt_nxt  = cnt_q + 1'b1;
  // Capture sequencer: registered RAM write port, status flags and record bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      p_q          <= '0;
      start_addr_q <= '0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      prev_q       <= '0;
      prev_ok_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      triggered_q  <= 1'b0;
      we_q         <= 1'b0;
    end else begin
      we_q <= accept && !abort_i;
      if (accept) begin
        waddr_q  <= wr_ptr_q;
        wdata_q  <= sample_in_i;
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (abort_i) begin
        state_q     <= IDLE;
        busy_q      <= 1'b0;
        done_q      <= 1'b0;
        triggered_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE, DONE: begin
            if (state_q == DONE) begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
            if (arm_i) begin
              wr_ptr_q    <= '0;
              cnt_q       <= '0;
              p_q         <= pretrig_i;
              prev_ok_q   <= 1'b0;
              done_q      <= 1'b0;
              triggered_q <= 1'b0;
              busy_q      <= 1'b1;
              state_q     <= (pretrig_i != '0) ? PRE : WAIT_TRIG;
            end
          end
          PRE: if (sample_valid_i) begin
            prev_q    <= sample_in_i;
            prev_ok_q <= 1'b1;
            cnt_q     <= cnt_nxt;
            if (cnt_nxt == p_q) state_q <= WAIT_TRIG;
          end
          WAIT_TRIG: if (sample_valid_i) begin
            prev_q    <= sample_in_i;
            prev_ok_q <= 1'b1;
            if (trig) begin
              triggered_q  <= 1'b1;
              start_addr_q <= wr_ptr_q - p_q;
              cnt_q        <= '0;
              state_q      <= (&p_q) ? DONE : POST;
            end
          end
          POST: if (sample_valid_i) begin
            cnt_q <= cnt_nxt;
            if (cnt_nxt == ~p_q) state_q <= DONE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
  assign bus.ram_cs       = busy_q | done_q;
  assign bus.ram_we       = we_q;
  assign bus.ram_addr_in  = waddr_q;
  assign bus.ram_data_in  = wdata_q;
  assign bus.ram_oe       = rd_en_i & done_q;
  assign bus.ram_addr_out = start_addr_q + rd_idx_i;
  assign rd_data_o        = bus.ram_data_out;
  assign busy_o           = busy_q;
  assign triggered_o      = triggered_q;
  assign done_o           = done_q;
  assign start_addr_o     = start_addr_q;
endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: scoreboard bench for capture_ctrl with a behavioural sample RAM
module tb_capture_ctrl;
  logic       clk, rst_n;
  logic       arm_i, abort_i, force_trig_i, sample_valid_i, trig_falling_i, rd_en_i;
  logic [7:0] sample_in_i, trig_level_i, rd_data_o;
  logic [3:0] pretrig_i, rd_idx_i, start_addr_o;
  logic       busy_o, triggered_o, done_o;
  int         checks = 0, errors = 0;
  logic [11:0] wq[$];
  logic [7:0]  rq[$];
  logic [3:0]  ea;
  logic [7:0]  mem [16];

  capture_ctrl_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  capture_ctrl #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .arm_i(arm_i), .abort_i(abort_i), .force_trig_i(force_trig_i),
    .sample_valid_i(sample_valid_i), .sample_in_i(sample_in_i), .trig_level_i(trig_level_i),
    .trig_falling_i(trig_falling_i), .pretrig_i(pretrig_i), .rd_en_i(rd_en_i), .rd_idx_i(rd_idx_i),
    .rd_data_o(rd_data_o), .busy_o(busy_o), .triggered_o(triggered_o), .done_o(done_o),
    .start_addr_o(start_addr_o), .bus(bus.master)
  );

  always @(posedge clk) if (bus.ram_cs && bus.ram_we) mem[bus.ram_addr_in] <= bus.ram_data_in;
  assign bus.ram_data_out = mem[bus.ram_addr_out];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  // Monitor: every RAM write and every enabled read is matched against the scoreboard queues
  always @(negedge clk) if (rst_n) begin
    if (bus.ram_we) begin
      checks++;
      if (wq.size() == 0) begin
        errors++;
        $display("FAIL ram_write: unexpected write addr %h data %h, required no write", bus.ram_addr_in, bus.ram_data_in);
      end else begin
        logic [11:0] e;
        e = wq.pop_front();
        if ({bus.ram_cs, bus.ram_addr_in, bus.ram_data_in} !== {1'b1, e}) begin
          errors++;
          $display("FAIL ram_write: got cs %b addr %h data %h, required cs 1 addr %h data %h",
                   bus.ram_cs, bus.ram_addr_in, bus.ram_data_in, e[11:8], e[7:0]);
        end
      end
    end
    if (bus.ram_oe) begin
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL ram_read: unexpected oe at idx %h, required no read", rd_idx_i);
      end else begin
        logic [7:0] e;
        e = rq.pop_front();
        if (rd_data_o !== e) begin
          errors++;
          $display("FAIL ram_read idx %h: got %h, required %h", rd_idx_i, rd_data_o, e);
        end
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", n, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic arm();
    arm_i = 1'b1;
    ea = 4'd0;
    step();
    arm_i = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic f = 1'b0);
    sample_valid_i = 1'b1;
    sample_in_i = d;
    force_trig_i = f;
    wq.push_back({ea, d});
    ea = ea + 4'd1;
    step();
    sample_valid_i = 1'b0;
    force_trig_i = 1'b0;
  endtask

  task automatic send_nw(input logic [7:0] d);
    sample_valid_i = 1'b1;
    sample_in_i = d;
    step();
    sample_valid_i = 1'b0;
  endtask

  task automatic rd(input logic [3:0] idx, input logic [7:0] exp);
    rd_en_i = 1'b1;
    rd_idx_i = idx;
    rq.push_back(exp);
    step();
    rd_en_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; arm_i = 0; abort_i = 0; force_trig_i = 0; sample_valid_i = 0;
    sample_in_i = 0; trig_level_i = 0; trig_falling_i = 0; pretrig_i = 0;
    rd_en_i = 0; rd_idx_i = 0; ea = 0;
    #12;
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_triggered", triggered_o, 0);
    chk("rst_we", bus.ram_we, 0);
    chk("rst_cs", bus.ram_cs, 0);
    rd_en_i = 1'b1;
    #1;
    chk("rst_oe", bus.ram_oe, 0);
    chk("rst_start", start_addr_o, 0);
    rd_en_i = 1'b0;
    rst_n = 1'b1;
    step();

    // Rising trigger on a ramp, P = 4, level 0x80, with valid gaps
    trig_level_i = 8'h80; trig_falling_i = 0; pretrig_i = 4'd4;
    arm();
    chk("t1_busy_armed", busy_o, 1);
    for (int i = 0; i < 20; i++) begin
      send(8'(i * 16));
      if (i == 1 || i == 6) repeat (2) step();
      if (i == 7) chk("t1_no_trig_yet", triggered_o, 0);
      if (i == 8) begin
        chk("t1_triggered", triggered_o, 1);
        chk("t1_start_addr", start_addr_o, 4);
      end
    end
    chk("t1_done_last_we", done_o, 0);
    chk("t1_busy_last_we", busy_o, 1);
    step();
    chk("t1_done", done_o, 1);
    chk("t1_busy_done", busy_o, 0);
    chk("t1_cs_done", bus.ram_cs, 1);
    rd(4'd0, 8'h40);
    rd(4'd4, 8'h80);
    rd(4'd15, 8'h30);

    // Falling trigger after wrapping, P = 4, level 0x40
    trig_level_i = 8'h40; trig_falling_i = 1; pretrig_i = 4'd4;
    arm();
    repeat (18) send(8'hFF);
    chk("t2_no_trig_flat", triggered_o, 0);
    send(8'h20);
    chk("t2_triggered", triggered_o, 1);
    chk("t2_start_addr", start_addr_o, 4'hE);
    for (int k = 1; k <= 11; k++) send(8'(k));
    step();
    chk("t2_done", done_o, 1);
    rd(4'd4, 8'h20);
    rd(4'd0, 8'hFF);
    rd(4'd15, 8'h0B);

    // P = 15: record complete on the trigger write itself
    trig_level_i = 8'h80; trig_falling_i = 0; pretrig_i = 4'd15;
    arm();
    repeat (15) send(8'h10);
    chk("t4_no_trig_pre", triggered_o, 0);
    send(8'h90);
    chk("t4_triggered", triggered_o, 1);
    chk("t4_start_addr", start_addr_o, 0);
    chk("t4_done_last_we", done_o, 0);
    step();
    chk("t4_done", done_o, 1);
    rd(4'd15, 8'h90);
    rd(4'd0, 8'h10);
    arm_i = 1'b1; abort_i = 1'b1;
    step();
    arm_i = 1'b0; abort_i = 1'b0;
    chk("arm_abort_done", done_o, 0);
    chk("arm_abort_busy", busy_o, 0);
    chk("arm_abort_cs", bus.ram_cs, 0);
    send_nw(8'h33);
    send_nw(8'h34);

    // P = 0 with first sample above level; arm in POST ignored; abort in POST
    trig_level_i = 8'h80; trig_falling_i = 0; pretrig_i = 4'd0;
    arm();
    chk("t5_busy", busy_o, 1);
    send(8'h90);
    chk("t5_first_no_trig", triggered_o, 0);
    send(8'h70);
    chk("t5_second_no_trig", triggered_o, 0);
    send(8'h85);
    chk("t5_triggered", triggered_o, 1);
    chk("t5_start_addr", start_addr_o, 2);
    send(8'h11);
    arm_i = 1'b1;
    step();
    arm_i = 1'b0;
    chk("t5_arm_post_busy", busy_o, 1);
    chk("t5_arm_post_trig", triggered_o, 1);
    send(8'h12);
    abort_i = 1'b1; sample_valid_i = 1'b1; sample_in_i = 8'h99;
    step();
    abort_i = 1'b0; sample_valid_i = 1'b0;
    chk("t5_abort_busy", busy_o, 0);
    chk("t5_abort_trig", triggered_o, 0);
    chk("t5_abort_done", done_o, 0);
    send_nw(8'h44);
    send_nw(8'h45);

    // force_trig on flat input, P = 2
    trig_level_i = 8'h80; trig_falling_i = 0; pretrig_i = 4'd2;
    arm();
    repeat (4) send(8'h55);
    chk("t3_no_trig_flat", triggered_o, 0);
    send(8'h55, 1'b1);
    chk("t3_triggered", triggered_o, 1);
    chk("t3_start_addr", start_addr_o, 2);
    repeat (12) send(8'h55);
    chk("t3_not_done_12", done_o, 0);
    send(8'h55);
    chk("t3_done_last_we", done_o, 0);
    step();
    chk("t3_done", done_o, 1);
    rd(4'd0, 8'h55);

    // Asynchronous reset in the middle of POST
    pretrig_i = 4'd3;
    arm();
    repeat (4) send(8'h55);
    send(8'h55, 1'b1);
    chk("mr_start_addr", start_addr_o, 1);
    send(8'h56);
    send(8'h57);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    rd_en_i = 1'b1;
    #1;
    chk("mr_busy", busy_o, 0);
    chk("mr_done", done_o, 0);
    chk("mr_triggered", triggered_o, 0);
    chk("mr_we", bus.ram_we, 0);
    chk("mr_cs", bus.ram_cs, 0);
    chk("mr_oe", bus.ram_oe, 0);
    chk("mr_start", start_addr_o, 0);
    #1;
    rd_en_i = 1'b0;
    rst_n = 1'b1;
    step();
    step();

    chk("wq_empty", wq.size(), 0);
    chk("rq_empty", rq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/capture_ctrl.md
Name: capture_ctrl

Overview:
- Sequences one capture into the sample RAM (sync-write / async-read, separate write and read address ports, cs/we/oe strobes).
- Writes incoming ADC samples into the RAM as a circular buffer and detects a level/edge trigger.
- Keeps PRETRIG samples from before the trigger, then stops after the buffer holds exactly one trigger-aligned record.
- Exposes a trigger-relative read port for the readout/display path.

Parameters:
ADDR_W, 8, RAM address width; DEPTH = 2**ADDR_W samples
DATA_W, 8, sample width

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
arm  in  1  start capture (pulse)
abort  in  1  return to IDLE (pulse)
force_trig  in  1  force trigger on next accepted sample in WAIT_TRIG
sample_valid  in  1  sample_in valid this cycle
sample_in  in  DATA_W  ADC sample
trig_level  in  DATA_W  unsigned trigger threshold
trig_falling  in  1  0 = rising edge, 1 = falling edge
pretrig  in  ADDR_W  samples kept before trigger, P
rd_en  in  1  read request
rd_idx  in  ADDR_W  record index, 0 = oldest
rd_data  out  DATA_W  sample at rd_idx (pass-through of ram_data_out)
ram_cs  out  1  RAM chip select
ram_we  out  1  RAM write strobe
ram_addr_in  out  ADDR_W  RAM write address
ram_data_in  out  DATA_W  RAM write data
ram_oe  out  1  RAM output enable
ram_addr_out  out  ADDR_W  RAM read address
ram_data_out  in  DATA_W  RAM read data
busy  out  1  capture in progress
triggered  out  1  trigger seen in current capture
done  out  1  record complete and readable
start_addr  out  ADDR_W  physical address of record index 0

Behaviour:
- Reset values (async, rst_n low): state IDLE; all outputs 0; wr_ptr 0; prev 0.
- States: IDLE, PRE, WAIT_TRIG, POST, DONE.
- Arming:
  - arm in IDLE or DONE: wr_ptr := 0, done := 0, triggered := 0, busy := 1.
  - Next state is PRE if P > 0, otherwise WAIT_TRIG.
  - arm in PRE, WAIT_TRIG or POST is ignored.
- Sample acceptance: a sample is accepted on a clk edge with sample_valid = 1 in PRE, WAIT_TRIG or POST.
- Write path (registered, 1-cycle latency):
  - On the accepting edge: ram_we := 1, ram_addr_in := wr_ptr, ram_data_in := sample_in, then wr_ptr := wr_ptr + 1 mod DEPTH.
  - ram_we is 0 in every cycle after a non-accepting edge.
  - ram_cs = busy | done.
- prev := sample_in on every accepted sample in PRE and WAIT_TRIG. prev_ok is set by the first accepted sample after arm.
- PRE: counts P accepted samples, then goes to WAIT_TRIG. Trigger is never evaluated in PRE.
- WAIT_TRIG:
  - Trigger condition: prev_ok and either
    - rising (trig_falling = 0): prev < level and sample_in >= level, or
    - falling (trig_falling = 1): prev > level and sample_in <= level, or
    - force_trig = 1.
  - The first sample after arm with P = 0 can only trigger via force_trig.
  - Writing continues circularly and may overwrite older samples.
  - On trigger, the trigger sample is written at trig_addr = wr_ptr, triggered := 1, and start_addr := trig_addr - P mod DEPTH.
  - Remaining post-trigger samples R := DEPTH - 1 - P. If R = 0, go to DONE; otherwise go to POST.
- POST: accepts R samples; the edge accepting the last one moves to DONE.
- DONE:
  - done and busy update on the edge after the final ram_we pulse, i.e. when the RAM commits it: done := 1, busy := 0.
  - The state holds until arm or abort.
- Read path (combinational):
  - ram_addr_out = start_addr + rd_idx mod DEPTH.
  - ram_oe = rd_en & done.
  - rd_data = ram_data_out.
  - Reads while not done return undefined data (oe low).
- abort in any state: IDLE, busy := 0, done := 0, triggered := 0, ram_we := 0. abort takes priority over a simultaneous arm.
- Reset mid-capture: immediate IDLE. RAM contents are not guaranteed.

Test Plan:
- Reset: rst_n low mid-cycle -> busy, done, triggered, ram_we, ram_oe, start_addr all 0 immediately.
- Rising trigger, ADDR_W = 4, P = 4, level 0x80: arm, feed ramp 0x00, 0x10, … -> sample 0x80 written at addr 8; start_addr = 4; 11 more writes at addr 9..15, 0..3; done one cycle after the last ram_we; rd_idx 0 -> 0x40, rd_idx 4 -> 0x80.
- Falling trigger with wrap, ADDR_W = 4, P = 4, level 0x40: 18 samples of 0xFF, then 0x20 -> trigger at addr 2; start_addr = 0xE; rd_idx 4 -> 0x20.
- force_trig on a flat 0x55 input, P = 2, ADDR_W = 4: force at the 5th sample -> triggered = 1, trigger at addr 4, start_addr = 2, done after 13 more samples.
- Boundaries, ADDR_W = 4:
  - P = 15 -> done immediately after the trigger write (R = 0).
  - P = 0 with a first sample above level -> no trigger until a real crossing.
  - sample_valid gaps -> no ram_we pulses during the gaps.
- Control conflicts:
  - arm while in POST -> ignored.
  - abort in POST -> IDLE next edge, busy 0, no further ram_we.
  - arm and abort on the same cycle -> IDLE.
